// File: rtl/ro_bit_harvester.sv
// ro_bit_harvester
// Consumes the free-running ring-oscillator lines: synchronises them into
// CLK, XOR-combines them once every SAMPLE_DIV cycles and packs the resulting
// bits MSB-first into OUT_W-bit words. Words leave on a valid/ready stream. A
// word that completes while the previous one is still unconsumed is dropped,
// and the drop is recorded in the sticky OVERRUN_O flag.
// Build option: define VN_DEBIAS_EN to insert a von Neumann debias stage
// between the raw sampled bit and the packer.
module ro_bit_harvester #(
   parameter int NUM_RO     = 8,
   parameter int SAMPLE_DIV = 16,
   parameter int OUT_W      = 8
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [NUM_RO-1:0] RO_IN,
   input  logic              EN,
   output logic [OUT_W-1:0]  DATA_O,
   output logic              VALID_O,
   input  logic              READY_I,
   output logic              OVERRUN_O
);

   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int CNT_W = $clog2(OUT_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(OUT_W - 1);

   // ------------------------------------------------------------------
   // Synchroniser: two flops per oscillator line
   // ------------------------------------------------------------------
   logic [NUM_RO-1:0] sync_vec;

   for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_sync
      (* ASYNC_REG = "TRUE" *) logic meta_q;
      (* ASYNC_REG = "TRUE" *) logic sync_q;

      // two-flop synchroniser for one oscillator line
      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
         end else begin
            meta_q <= RO_IN[gi];
            sync_q <= meta_q;
         end
      end

      assign sync_vec[gi] = sync_q;
   end

   // ------------------------------------------------------------------
   // Sample-rate divider
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             strobe;
   logic             raw_bit;

   assign strobe  = EN && (div_cnt_q == DIV_LAST);
   assign raw_bit = ^sync_vec;

   // divider advances while enabled, wraps after the strobe, held at 0 when disabled
   always_comb begin
      div_cnt_d = div_cnt_q;
      if (!EN) begin
         div_cnt_d = '0;
      end else if (strobe) begin
         div_cnt_d = '0;
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   // divider state register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Bit source: raw strobe bits, or von Neumann pairs
   // ------------------------------------------------------------------
   logic emit_valid;
   logic emit_bit;

`ifdef VN_DEBIAS_EN
   typedef enum logic {
      WAIT_FIRST  = 1'b0,
      WAIT_SECOND = 1'b1
   } vn_state_t;

   vn_state_t state_q, state_d;
   logic      first_q, first_d;

   // debias FSM: pair 10 emits 1, pair 01 emits 0, equal pairs emit nothing
   always_comb begin
      state_d    = state_q;
      first_d    = first_q;
      emit_valid = 1'b0;
      emit_bit   = 1'b0;
      if (!EN) begin
         state_d = WAIT_FIRST;
      end else if (strobe) begin
         case (state_q)
            WAIT_FIRST: begin
               first_d = raw_bit;
               state_d = WAIT_SECOND;
            end
            WAIT_SECOND: begin
               state_d = WAIT_FIRST;
               if (first_q != raw_bit) begin
                  emit_valid = 1'b1;
                  emit_bit   = first_q;
               end
            end
            default: state_d = WAIT_FIRST;
         endcase
      end
   end

   // debias FSM state register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= WAIT_FIRST;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
      end
   end
`else
   assign emit_valid = strobe;
   assign emit_bit   = raw_bit;
`endif

   // ------------------------------------------------------------------
   // Packer: first emitted bit ends up in the MSB
   // ------------------------------------------------------------------
   logic [OUT_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [OUT_W-1:0] word_next;
   logic             word_done;

   assign word_next = {shift_q[OUT_W-2:0], emit_bit};
   assign word_done = emit_valid && (bit_cnt_q == BIT_LAST);

   // shift in each emitted bit; restart the word when it completes or EN drops
   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      if (!EN) begin
         shift_d   = '0;
         bit_cnt_d = '0;
      end else if (emit_valid) begin
         if (word_done) begin
            shift_d   = '0;
            bit_cnt_d = '0;
         end else begin
            shift_d   = word_next;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
      end
   end

   // packer state registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Output register and valid/ready handshake
   // ------------------------------------------------------------------
   logic [OUT_W-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;

   // load a finished word if the slot is free or emptying this cycle, else drop it
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (word_done) begin
         if (!valid_q || READY_I) begin
            data_d  = word_next;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && READY_I) begin
         valid_d = 1'b0;
      end
   end

   // output registers; overrun is only cleared by reset
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign DATA_O    = data_q;
   assign VALID_O   = valid_q;
   assign OVERRUN_O = overrun_q;

endmodule

// File: tb/tb_ro_bit_harvester.sv
// Testbench for ro_bit_harvester: random stimulus checked every cycle against
// a queue-based reference model, plus directed scenario checks.
`timescale 1ns/1ps
module tb_ro_bit_harvester;

   localparam int NUM_RO     = 8;
   localparam int SAMPLE_DIV = 4;
   localparam int OUT_W      = 8;
`ifdef VN_DEBIAS_EN
   localparam int MUL = 2;
`else
   localparam int MUL = 1;
`endif
   localparam int W = OUT_W * SAMPLE_DIV * MUL;   // cycles per word for ideal stimulus

   logic              CLK = 1'b0;
   logic              RESET_N;
   logic [NUM_RO-1:0] RO_IN;
   logic              EN;
   logic              READY_I;
   logic [OUT_W-1:0]  DATA_O;
   logic              VALID_O;
   logic              OVERRUN_O;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   ro_bit_harvester #(
      .NUM_RO    (NUM_RO),
      .SAMPLE_DIV(SAMPLE_DIV),
      .OUT_W     (OUT_W)
   ) dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .RO_IN    (RO_IN),
      .EN       (EN),
      .DATA_O   (DATA_O),
      .VALID_O  (VALID_O),
      .READY_I  (READY_I),
      .OVERRUN_O(OVERRUN_O)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ------------------------------------------------------------------
   // Reference model: delay line, enabled-cycle count, bit queues
   // ------------------------------------------------------------------
   logic [NUM_RO-1:0] m_s1, m_s2;
   int                m_en_cycles;
   bit                m_bits[$];
`ifdef VN_DEBIAS_EN
   bit                m_pair[$];
`endif
   logic [OUT_W-1:0]  m_data;
   logic              m_valid;
   logic              m_ovr;

   logic [OUT_W-1:0]  stim_word[$];

   task automatic model_reset();
      m_s1 = '0;
      m_s2 = '0;
      m_en_cycles = 0;
      m_bits.delete();
`ifdef VN_DEBIAS_EN
      m_pair.delete();
`endif
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_edge();
      logic             raw;
      logic             done;
      logic [OUT_W-1:0] word;
      bit               emit;
      bit               ebit;
      if (!RESET_N) begin
         model_reset();
         return;
      end
      done = 1'b0;
      emit = 1'b0;
      ebit = 1'b0;
      word = '0;
      if (!EN) begin
         m_en_cycles = 0;
         m_bits.delete();
`ifdef VN_DEBIAS_EN
         m_pair.delete();
`endif
      end else begin
         if (m_en_cycles % SAMPLE_DIV == SAMPLE_DIV - 1) begin
            raw = ^m_s2;
`ifdef VN_DEBIAS_EN
            m_pair.push_back(raw);
            if (m_pair.size() == 2) begin
               if (m_pair[0] != m_pair[1]) begin
                  emit = 1'b1;
                  ebit = m_pair[0];
               end
               m_pair.delete();
            end
`else
            emit = 1'b1;
            ebit = raw;
`endif
            if (emit) begin
               m_bits.push_back(ebit);
               if (m_bits.size() == OUT_W) begin
                  for (int i = 0; i < OUT_W; i++) word[OUT_W-1-i] = m_bits[i];
                  done = 1'b1;
                  m_bits.delete();
               end
            end
         end
         m_en_cycles++;
      end
      if (done) begin
         if (!m_valid || READY_I) begin
            m_data  = word;
            m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_valid && READY_I) begin
         m_valid = 1'b0;
      end
      m_s2 = m_s1;
      m_s1 = RO_IN;
   endtask

   // drive inputs, advance one clock, update model, settle for sampling
   task automatic step(input logic en, input logic [NUM_RO-1:0] ro, input logic rdy);
      EN      = en;
      RO_IN   = ro;
      READY_I = rdy;
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      model_reset();
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      RESET_N = 1'b1;
   endtask

   // random RO vector whose XOR-reduction equals p
   function automatic logic [NUM_RO-1:0] rand_ro(input logic p);
      logic [NUM_RO-1:0] v;
      v = NUM_RO'($urandom);
      v[0] = p ^ (^v[NUM_RO-1:1]);
      return v;
   endfunction

   // parity to present at enabled edge e (1-based) so that stim_word comes out
   function automatic logic stim_parity(input int e);
      int               j;
      int               bi;
      logic             b;
      logic [OUT_W-1:0] w;
      j = (e - 1) / SAMPLE_DIV;
`ifdef VN_DEBIAS_EN
      bi = j / 2;
`else
      bi = j;
`endif
      if (bi / OUT_W >= stim_word.size()) return 1'b0;
      w = stim_word[bi / OUT_W];
      b = w[OUT_W-1-(bi % OUT_W)];
`ifdef VN_DEBIAS_EN
      if (j % 2 == 1) b = ~b;
`endif
      return b;
   endfunction

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   task automatic test_reset();
      RESET_N = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if ({DATA_O, VALID_O, OVERRUN_O} !== {OUT_W'(0), 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_async: got data=%h valid=%b ovr=%b, want 00 0 0", DATA_O, VALID_O, OVERRUN_O);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'($urandom_range(0, 1)), NUM_RO'($urandom), 1'($urandom_range(0, 1)));
         n_tests++;
         if ({DATA_O, VALID_O, OVERRUN_O} !== {OUT_W'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold cyc %0d: got data=%h valid=%b ovr=%b, want 00 0 0", i, DATA_O, VALID_O, OVERRUN_O);
         end
      end
      RESET_N = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step(1'b0, NUM_RO'($urandom), 1'($urandom_range(0, 1)));
         n_tests++;
         if (VALID_O !== 1'b0 || OVERRUN_O !== 1'b0) begin
            n_fail++;
            $display("FAIL en_low_idle cyc %0d: got valid=%b ovr=%b, want 0 0", i, VALID_O, OVERRUN_O);
         end
      end
   endtask

   task automatic test_raw_const(input logic [NUM_RO-1:0] ro, input logic [OUT_W-1:0] exp_word);
      int               first_rise;
      int               n_valid;
      logic [OUT_W-1:0] rise_data;
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, ro, 1'b1);
      first_rise = -1;
      n_valid    = 0;
      rise_data  = '0;
      for (int e = 1; e <= 96; e++) begin
         step(1'b1, ro, 1'b1);
         n_tests++;
         if ({DATA_O, VALID_O, OVERRUN_O} !== {m_data, m_valid, m_ovr}) begin
            n_fail++;
            $display("FAIL raw_const_model ro=%h edge %0d: got %h %b %b, want %h %b %b",
                     ro, e, DATA_O, VALID_O, OVERRUN_O, m_data, m_valid, m_ovr);
         end
         if (VALID_O === 1'b1) begin
            n_valid++;
            if (first_rise < 0) begin
               first_rise = e;
               rise_data  = DATA_O;
            end
         end
      end
`ifdef VN_DEBIAS_EN
      n_tests++;
      if (n_valid != 0) begin
         n_fail++;
         $display("FAIL vn_const_no_output ro=%h: got %0d valid cycles, want 0 (word %h unused)", ro, n_valid, exp_word);
      end
`else
      n_tests++;
      if (first_rise != 32) begin
         n_fail++;
         $display("FAIL raw_first_latency ro=%h: got edge %0d, want 32", ro, first_rise);
      end
      n_tests++;
      if (rise_data !== exp_word) begin
         n_fail++;
         $display("FAIL raw_const_word ro=%h: got %h, want %h", ro, rise_data, exp_word);
      end
      n_tests++;
      if (n_valid != 3) begin
         n_fail++;
         $display("FAIL raw_word_rate ro=%h: got %0d words in 96 cycles, want 3", ro, n_valid);
      end
`endif
   endtask

   task automatic test_alternate();
      int               first_rise;
      logic [OUT_W-1:0] rise_data;
      logic [NUM_RO-1:0] ro;
      int               exp_rise;
      logic [OUT_W-1:0] exp_word;
`ifdef VN_DEBIAS_EN
      exp_rise = 64;
      exp_word = 8'hFF;
`else
      exp_rise = 32;
      exp_word = 8'hAA;
`endif
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 8'h01, 1'b0);
      first_rise = -1;
      rise_data  = '0;
      for (int e = 1; e <= 72; e++) begin
         ro = (((e - 1) / SAMPLE_DIV) % 2 == 0) ? 8'h01 : 8'h00;
         step(1'b1, ro, 1'b0);
         n_tests++;
         if ({DATA_O, VALID_O, OVERRUN_O} !== {m_data, m_valid, m_ovr}) begin
            n_fail++;
            $display("FAIL alternate_model edge %0d: got %h %b %b, want %h %b %b",
                     e, DATA_O, VALID_O, OVERRUN_O, m_data, m_valid, m_ovr);
         end
         if (VALID_O === 1'b1 && first_rise < 0) begin
            first_rise = e;
            rise_data  = DATA_O;
         end
      end
      n_tests++;
      if (first_rise != exp_rise || rise_data !== exp_word) begin
         n_fail++;
         $display("FAIL alternate_word: got edge %0d data %h, want edge %0d data %h",
                  first_rise, rise_data, exp_rise, exp_word);
      end
   endtask

   task automatic test_overrun();
      logic [OUT_W-1:0] a;
      a = OUT_W'($urandom);
      stim_word.delete();
      stim_word.push_back(a);
      stim_word.push_back(~a);
      stim_word.push_back(OUT_W'($urandom));
      do_reset();
      for (int e = 1; e <= 2 * W; e++) begin
         step(1'b1, rand_ro(stim_parity(e)), 1'b0);
         n_tests++;
         if ({DATA_O, VALID_O, OVERRUN_O} !== {m_data, m_valid, m_ovr}) begin
            n_fail++;
            $display("FAIL overrun_model edge %0d: got %h %b %b, want %h %b %b",
                     e, DATA_O, VALID_O, OVERRUN_O, m_data, m_valid, m_ovr);
         end
         if (e == W) begin
            n_tests++;
            if (VALID_O !== 1'b1 || DATA_O !== a || OVERRUN_O !== 1'b0) begin
               n_fail++;
               $display("FAIL overrun_first_word: got %h %b %b, want %h 1 0", DATA_O, VALID_O, OVERRUN_O, a);
            end
         end
         if (e == 2 * W) begin
            n_tests++;
            if (VALID_O !== 1'b1 || DATA_O !== a || OVERRUN_O !== 1'b1) begin
               n_fail++;
               $display("FAIL overrun_drop: got %h %b %b, want %h 1 1", DATA_O, VALID_O, OVERRUN_O, a);
            end
         end
      end
      step(1'b1, rand_ro(stim_parity(2 * W + 1)), 1'b1);
      n_tests++;
      if (VALID_O !== 1'b0 || OVERRUN_O !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_sticky_after_xfer: got valid=%b ovr=%b, want 0 1", VALID_O, OVERRUN_O);
      end
   endtask

   task automatic test_ready_at_complete();
      logic [OUT_W-1:0] a;
      logic [OUT_W-1:0] b;
      a = OUT_W'($urandom);
      b = ~a;
      stim_word.delete();
      stim_word.push_back(a);
      stim_word.push_back(b);
      do_reset();
      for (int e = 1; e <= 2 * W; e++) begin
         step(1'b1, rand_ro(stim_parity(e)), (e == 2 * W) ? 1'b1 : 1'b0);
         n_tests++;
         if ({DATA_O, VALID_O, OVERRUN_O} !== {m_data, m_valid, m_ovr}) begin
            n_fail++;
            $display("FAIL ready_complete_model edge %0d: got %h %b %b, want %h %b %b",
                     e, DATA_O, VALID_O, OVERRUN_O, m_data, m_valid, m_ovr);
         end
      end
      n_tests++;
      if (VALID_O !== 1'b1 || OVERRUN_O !== 1'b0 || DATA_O !== b) begin
         n_fail++;
         $display("FAIL ready_at_complete: got %h %b %b, want %h 1 0", DATA_O, VALID_O, OVERRUN_O, b);
      end
   endtask

   task automatic test_enable_drop();
      int               first_rise;
      logic [OUT_W-1:0] rise_data;
      logic [OUT_W-1:0] c;
      stim_word.delete();
      stim_word.push_back(OUT_W'($urandom));
      do_reset();
      for (int e = 1; e <= 5 * SAMPLE_DIV * MUL; e++) begin
         step(1'b1, rand_ro(stim_parity(e)), 1'b1);
         n_tests++;
         if ({DATA_O, VALID_O, OVERRUN_O} !== {m_data, m_valid, m_ovr}) begin
            n_fail++;
            $display("FAIL en_drop_partial edge %0d: got %h %b %b, want %h %b %b",
                     e, DATA_O, VALID_O, OVERRUN_O, m_data, m_valid, m_ovr);
         end
      end
      for (int i = 0; i < 3; i++) step(1'b0, NUM_RO'($urandom), 1'b1);
      c = OUT_W'($urandom) | OUT_W'(1);
      stim_word.delete();
      stim_word.push_back(c);
      stim_word.push_back(OUT_W'($urandom));
      first_rise = -1;
      rise_data  = '0;
      for (int e = 1; e <= W + 10; e++) begin
         step(1'b1, rand_ro(stim_parity(e)), 1'b0);
         n_tests++;
         if ({DATA_O, VALID_O, OVERRUN_O} !== {m_data, m_valid, m_ovr}) begin
            n_fail++;
            $display("FAIL en_drop_restart edge %0d: got %h %b %b, want %h %b %b",
                     e, DATA_O, VALID_O, OVERRUN_O, m_data, m_valid, m_ovr);
         end
         if (VALID_O === 1'b1 && first_rise < 0) begin
            first_rise = e;
            rise_data  = DATA_O;
         end
      end
      n_tests++;
      if (first_rise != W || rise_data !== c) begin
         n_fail++;
         $display("FAIL en_drop_fresh_word: got edge %0d data %h, want edge %0d data %h", first_rise, rise_data, W, c);
      end
      #2;
      RESET_N = 1'b0;
      #1;
      n_tests++;
      if ({DATA_O, VALID_O, OVERRUN_O} !== {OUT_W'(0), 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_word: got %h %b %b, want 00 0 0", DATA_O, VALID_O, OVERRUN_O);
      end
      model_reset();
      step(1'b1, NUM_RO'($urandom), 1'b0);
      RESET_N = 1'b1;
   endtask

   task automatic test_back_to_back();
      int k;
      stim_word.delete();
      for (int i = 0; i < 6; i++) stim_word.push_back(OUT_W'($urandom));
      do_reset();
      k = 0;
      for (int e = 1; e <= 6 * W + 2; e++) begin
         step(1'b1, rand_ro(stim_parity(e)), 1'b1);
         n_tests++;
         if ({DATA_O, VALID_O, OVERRUN_O} !== {m_data, m_valid, m_ovr}) begin
            n_fail++;
            $display("FAIL b2b_model edge %0d: got %h %b %b, want %h %b %b",
                     e, DATA_O, VALID_O, OVERRUN_O, m_data, m_valid, m_ovr);
         end
         if (VALID_O === 1'b1) begin
            n_tests++;
            if (k >= 6 || DATA_O !== stim_word[k % 6]) begin
               n_fail++;
               $display("FAIL b2b_word %0d: got %h, want %h", k, DATA_O, stim_word[k % 6]);
            end else begin
               $display("[TB] b2b word %0d data=%h", k, DATA_O);
            end
            k++;
         end
      end
      n_tests++;
      if (k != 6) begin
         n_fail++;
         $display("FAIL b2b_word_count: got %0d, want 6", k);
      end
   endtask

   task automatic test_random();
      logic en;
      logic rdy;
      logic xfer;
      en = 1'b1;
      do_reset();
      for (int e = 1; e <= 1500; e++) begin
         if (en) en = ($urandom_range(0, 99) >= 2);
         else    en = ($urandom_range(0, 99) < 30);
         rdy  = ($urandom_range(0, 3) == 0);
         xfer = VALID_O && rdy;
         step(en, NUM_RO'($urandom), rdy);
         if (xfer) $display("[TB] rand xfer at cycle %0d", e);
         n_tests++;
         if ({DATA_O, VALID_O, OVERRUN_O} !== {m_data, m_valid, m_ovr}) begin
            n_fail++;
            $display("FAIL random_model cyc %0d: got %h %b %b, want %h %b %b",
                     e, DATA_O, VALID_O, OVERRUN_O, m_data, m_valid, m_ovr);
         end
      end
   endtask

   initial begin
      RESET_N = 1'b1;
      EN      = 1'b0;
      READY_I = 1'b0;
      RO_IN   = '0;
      model_reset();
      #2;
      test_reset();
      test_raw_const(8'h01, 8'hFF);
      test_raw_const(8'h03, 8'h00);
      test_alternate();
      test_overrun();
      test_ready_at_complete();
      test_enable_drop();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ro_bit_harvester.md
# ro_bit_harvester

Harvests entropy from a bank of free-running ring oscillators (`RO` instances) in the system clock domain. It is the consumer end of the RO `CLK_O` outputs: it synchronises the raw oscillator lines, XOR-combines them at a programmable sample rate, and optionally debiases the result. It then packs the bits into words and presents them on a valid/ready stream for the downstream TRNG logic (FIFO / Ethernet packetiser).

## Interface
Parameters:
- `NUM_RO`, 8: number of ring-oscillator inputs, ≥1.
- `SAMPLE_DIV`, 16: clock cycles per raw sample, ≥2.
- `OUT_W`, 8: output word width, ≥2.

Ports:
- `CLK` input, 1: system clock.
- `RESET_N` input, 1: asynchronous, active-low reset.
- `RO_IN` input, `NUM_RO`: raw `CLK_O` lines from the RO instances; asynchronous to `CLK`.
- `EN` input, 1: harvesting enable.
- `DATA_O` output, `OUT_W`: random word.
- `VALID_O` output, 1: `DATA_O` holds an unconsumed word.
- `READY_I` input, 1: downstream accepts the word.
- `OVERRUN_O` output, 1: sticky flag; a completed word was dropped.

## Operation
- **Synchroniser.** Two flops per `RO_IN` bit, marked ASYNC_REG, reset to 0.
- **Divider.** `div_cnt` has width ceil(log2(SAMPLE_DIV)).
  - Increments each cycle with `EN`=1 and wraps at SAMPLE_DIV-1.
  - The sample strobe is the cycle with `EN`=1 and `div_cnt`==SAMPLE_DIV-1.
- **Raw bit.** XOR-reduction of the synchronised vector, captured on the strobe edge.
- **Debias FSM** (only when `VN_DEBIAS_EN` is defined). States: `WAIT_FIRST`, `WAIT_SECOND`.
  - `WAIT_FIRST` + strobe: store raw bit, go to `WAIT_SECOND`.
  - `WAIT_SECOND` + strobe: pair 01 emits 0; pair 10 emits 1; pairs 00 and 11 emit nothing. Return to `WAIT_FIRST` in all cases.
- **Packer.** Each emitted bit is shifted in at bit 0 and prior bits move left, so the first bit ends in the MSB.
  - `bit_cnt` counts 0..OUT_W-1.
  - The emitting edge that supplies bit OUT_W is the word-complete edge. At that edge `bit_cnt` returns to 0.
- **Output register.** On word-complete:
  - If `VALID_O`=0, or `VALID_O`&&`READY_I` in the same cycle: load `DATA_O` and set `VALID_O`=1.
  - Otherwise: drop the word, leave `DATA_O` unchanged, set `OVERRUN_O`=1.
- **Handshake.** A word transfers on a cycle with `VALID_O`&&`READY_I`. `VALID_O` drops on the next edge unless a new word loads on that same edge.
  - `DATA_O` is stable while `VALID_O`=1 and `READY_I`=0.
- **`EN`=0.** Holds `div_cnt`=0, `bit_cnt`=0, the FSM in `WAIT_FIRST`, and clears the partial shift register. The output register and handshake keep working.
- **`OVERRUN_O`.** Cleared only by reset.

## Timing
- **Reset values.** `DATA_O`=0, `VALID_O`=0, `OVERRUN_O`=0, all counters 0, FSM in `WAIT_FIRST`, synchronisers 0.
- **Input latency.** `RO_IN` to synchroniser output is 2 edges.
- **Raw mode.** With `RO_IN` stable ≥2 cycles before each strobe and `EN` rising before edge 1, `VALID_O` rises after edge OUT_W×SAMPLE_DIV. Steady rate is one word per OUT_W×SAMPLE_DIV cycles.
- **Debias mode.** At least 2×OUT_W×SAMPLE_DIV cycles per word; the rate depends on the data.
- **Reset mid-word.** Asynchronous assertion clears everything immediately; a partial word is lost.
- **`EN` mid-word.** Deassertion discards the partial word. An already-valid `DATA_O` is kept.

## Configuration
- `VN_DEBIAS_EN` defined: the von Neumann debias FSM is inserted between raw bit and packer.
- `VN_DEBIAS_EN` undefined: every raw bit goes straight to the packer; no FSM is generated.

## Test plan
Common setup: NUM_RO=8, SAMPLE_DIV=4, OUT_W=8.
1. Hold `RESET_N`=0 with random inputs -> `DATA_O`=8'h00, `VALID_O`=0, `OVERRUN_O`=0. Release with `EN`=0 for 50 cycles -> `VALID_O` stays 0.
2. Raw mode, `RO_IN`=8'h01 constant, `EN`=1, `READY_I`=1 -> `VALID_O` rises after edge 32 with `DATA_O`=8'hFF, then one word every 32 cycles. `RO_IN`=8'h03 -> words 8'h00.
3. Raw mode, `RO_IN` alternating 8'h01/8'h00 per strobe starting with 8'h01 -> `DATA_O`=8'hAA. Same stimulus with `VN_DEBIAS_EN` -> `DATA_O`=8'hFF after 64 cycles. Constant 8'h01 with `VN_DEBIAS_EN` -> `VALID_O` never asserts.
4. Raw mode, `READY_I`=0, constant 8'h01 -> first word 8'hFF held. At edge 64 `OVERRUN_O`=1 and `DATA_O` is still the first word. Then raise `READY_I` -> one transfer, and `OVERRUN_O` remains 1.
5. `READY_I` pulsed high exactly in the cycle before a word-complete edge while `VALID_O`=1 -> old word transfers, new word loads, `VALID_O` stays 1, `OVERRUN_O` stays 0.
6. Mid-word (after 5 bits), drop `EN` for 3 cycles, then restore it -> the next word needs the full 32 cycles and contains no stale bits. Then assert `RESET_N`=0 mid-word -> all outputs return to reset values asynchronously.
